// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller (M stage): SR/Cause/EPC/PRId, request generation, mfc0/mtc0.
// Optional CP0_EPC_BYPASS_EN forwards an in-flight mtc0 EPC write straight to EPCOut.
module cp0_exc_ctrl #(
   parameter logic [31:0] PRID_VALUE = 32'h2022_0707
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] PC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        Req,
   output logic [31:0] EPCOut,
   output logic [31:0] DOut
);

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic        sr_write;
   logic        epc_write;
   logic [31:0] epc_target;

   assign int_req   = ie & ~exl & (|(HWInt & im));
   assign exc_req   = ~exl & (ExcCodeIn != 5'd0);
   assign Req       = int_req | exc_req;
   assign sr_write  = WE & (A2 == REG_SR);
   assign epc_write = WE & (A2 == REG_EPC);

   // A delay-slot instruction restarts at its branch, one word earlier.
   assign epc_target = BDIn ? (PC - 32'd4) : PC;

   always_ff @(posedge clk) begin
      if (!reset) begin
         im       <= 6'd0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= 6'd0;
         exc_code <= 5'd0;
         epc      <= 32'd0;
      end else begin
         ip <= HWInt;
         if (Req) begin
            exl      <= 1'b1;
            bd       <= BDIn;
            exc_code <= int_req ? 5'd0 : ExcCodeIn;
            epc      <= epc_target & 32'hFFFF_FFFC;
         end else begin
            // eret overrides only the EXL bit of a same-cycle SR write.
            if (sr_write) begin
               im  <= DIn[15:10];
               exl <= DIn[1] & ~EXLClr;
               ie  <= DIn[0];
            end else if (EXLClr) begin
               exl <= 1'b0;
            end
            if (epc_write) begin
               epc <= DIn;
            end
         end
      end
   end

   always_comb begin
      DOut = 32'd0;
      case (A1)
         REG_SR:    DOut = {16'd0, im, 8'd0, exl, ie};
         REG_CAUSE: DOut = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
         REG_EPC:   DOut = epc;
         REG_PRID:  DOut = PRID_VALUE;
         default:   DOut = 32'd0;
      endcase
   end

`ifdef CP0_EPC_BYPASS_EN
   assign EPCOut = (epc_write & ~Req) ? DIn : epc;
`else
   assign EPCOut = epc;
`endif

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed plan cases plus random traffic
// compared against a word-level CP0 model.
module tb_cp0_exc_ctrl;

   localparam logic [31:0] PRID = 32'h2022_0707;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  a1, a2, exc;
   logic [31:0] din, pc, epc_out, dout;
   logic        we, bd_in, exl_clr, req;
   logic [5:0]  hw;

   cp0_exc_ctrl dut (
      .clk(clk), .reset(reset), .A1(a1), .A2(a2), .DIn(din), .WE(we),
      .PC(pc), .BDIn(bd_in), .ExcCodeIn(exc), .HWInt(hw), .EXLClr(exl_clr),
      .Req(req), .EPCOut(epc_out), .DOut(dout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state kept as architectural 32-bit register words.
   logic [31:0] m_sr, m_cause, m_epc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic bit m_int_req();
      return m_sr[0] && !m_sr[1] && ((hw & m_sr[15:10]) != 6'd0);
   endfunction

   function automatic bit m_req();
      return m_int_req() || (!m_sr[1] && exc != 5'd0);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] m_epc_out();
`ifdef CP0_EPC_BYPASS_EN
      if (we && a2 == 5'd14 && !m_req()) return din;
`endif
      return m_epc;
   endfunction

   // Drive inputs mid-cycle, let them settle, compare the combinational outputs.
   task automatic set_in(input logic [4:0] a1_v, input logic [4:0] a2_v, input logic [31:0] din_v,
                         input logic we_v, input logic [31:0] pc_v, input logic bd_v,
                         input logic [4:0] exc_v, input logic [5:0] hw_v, input logic clr_v);
      a1 = a1_v; a2 = a2_v; din = din_v; we = we_v; pc = pc_v;
      bd_in = bd_v; exc = exc_v; hw = hw_v; exl_clr = clr_v;
      #1;
      check_eq("req", {31'd0, req}, {31'd0, m_req()});
      check_eq("dout", dout, m_read(a1));
      check_eq("epc_out", epc_out, m_epc_out());
   endtask

   // Advance one clock edge and step the model with the same inputs.
   task automatic tick();
      logic [31:0] n_sr, n_cause, n_epc;
      logic [4:0]  code;
      n_sr    = m_sr;
      n_epc   = m_epc;
      n_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw} << 10);
      if (m_req()) begin
         code    = m_int_req() ? 5'd0 : exc;
         n_sr    = m_sr | 32'h2;
         n_cause = ({31'd0, bd_in} << 31) | ({26'd0, hw} << 10) | ({27'd0, code} << 2);
         n_epc   = (bd_in ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
      end else begin
         if (we && a2 == 5'd12) n_sr = din & 32'h0000_FC03;
         if (exl_clr) n_sr = n_sr & ~32'h2;
         if (we && a2 == 5'd14) n_epc = din;
      end
      @(posedge clk);
      m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      a1 = 0; a2 = 0; din = 0; we = 0; pc = 0; bd_in = 0; exc = 0; hw = 0; exl_clr = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      m_sr = 0; m_cause = 0; m_epc = 0;

      // Reset state and PRId
      set_in(12, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("rst_sr", dout, 32'd0);
      check_eq("rst_req", {31'd0, req}, 32'd0);
      set_in(13, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("rst_cause", dout, 32'd0);
      set_in(14, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("rst_epc", dout, 32'd0);
      check_eq("rst_epc_out", epc_out, 32'd0);
      set_in(15, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("prid", dout, PRID);
      tick();

      // Synchronous exception
      set_in(12, 12, 32'h0000_FC01, 1, 0, 0, 0, 0, 0);
      tick();
      set_in(13, 0, 0, 0, 32'h0000_3010, 0, 12, 0, 0);
      check_eq("sync_req", {31'd0, req}, 32'd1);
      tick();
      set_in(14, 0, 0, 0, 32'h0000_3014, 0, 12, 0, 0);
      check_eq("sync_nested_req", {31'd0, req}, 32'd0);
      check_eq("sync_epc", dout, 32'h0000_3010);
      check_eq("sync_epc_out", epc_out, 32'h0000_3010);
      set_in(13, 0, 0, 0, 32'h0000_3014, 0, 12, 0, 0);
      check_eq("sync_cause", dout, 32'h0000_0030);
      set_in(12, 0, 0, 0, 32'h0000_3014, 0, 0, 0, 0);
      check_eq("sync_sr", dout, 32'h0000_FC03);

      // eret clears EXL
      set_in(12, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      set_in(12, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("eret_sr", dout, 32'h0000_FC01);

      // Delay-slot interrupt
      set_in(12, 12, 32'h0000_0401, 1, 0, 0, 0, 0, 0);
      tick();
      set_in(14, 0, 0, 0, 32'h0000_3024, 1, 0, 6'b000001, 0);
      check_eq("ds_req", {31'd0, req}, 32'd1);
      tick();
      set_in(14, 0, 0, 0, 0, 0, 0, 6'b000001, 0);
      check_eq("ds_epc", dout, 32'h0000_3020);
      set_in(13, 0, 0, 0, 0, 0, 0, 6'b000001, 0);
      check_eq("ds_cause", dout, 32'h8000_0400);
      set_in(12, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();

      // Masking: line not in IM, then IE=0
      set_in(13, 0, 0, 0, 0, 0, 0, 6'b000010, 0);
      check_eq("mask_im_req", {31'd0, req}, 32'd0);
      tick();
      set_in(13, 0, 0, 0, 0, 0, 0, 6'b000010, 0);
      check_eq("mask_ip", (dout >> 10) & 32'h3F, 32'h2);
      set_in(12, 12, 32'h0000_FC00, 1, 0, 0, 0, 6'b000010, 0);
      tick();
      set_in(12, 0, 0, 0, 0, 0, 0, 6'b000010, 0);
      check_eq("mask_ie_req", {31'd0, req}, 32'd0);
      tick();

      // Req beats mtc0 and eret in the same cycle
      set_in(12, 12, 32'h0000_0001, 1, 0, 0, 0, 0, 0);
      tick();
      set_in(14, 14, 32'hDEAD_BEEC, 1, 32'h0000_3040, 0, 4, 0, 1);
      check_eq("prio_req", {31'd0, req}, 32'd1);
      tick();
      set_in(14, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("prio_epc", dout, 32'h0000_3040);
      set_in(12, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("prio_exl", dout, 32'h0000_0003);

      // eret with same-cycle SR write: written value, EXL forced low
      set_in(12, 12, 32'h0000_0403, 1, 0, 0, 0, 0, 1);
      tick();
      set_in(12, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("eret_wr_sr", dout, 32'h0000_0401);

      // EPC write: same-cycle read returns old value; EPCOut timing
      set_in(14, 14, 32'h0000_3100, 1, 0, 0, 0, 0, 0);
      check_eq("rw_old", dout, 32'h0000_3040);
`ifdef CP0_EPC_BYPASS_EN
      check_eq("bypass_now", epc_out, 32'h0000_3100);
`else
      check_eq("no_bypass_now", epc_out, 32'h0000_3040);
`endif
      tick();
      set_in(14, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("epc_out_next", epc_out, 32'h0000_3100);
      tick();

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [4:0]  r_a1, r_a2, r_exc;
         logic [5:0]  r_hw;
         logic [31:0] r_din;
         r_a1  = 5'($urandom_range(10, 17));
         r_a2  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(12, 15)) : 5'($urandom_range(0, 31));
         r_exc = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         r_hw  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         r_din = $urandom;
         set_in(r_a1, r_a2, r_din, ($urandom_range(0, 2) == 0), $urandom,
                1'($urandom_range(0, 1)), r_exc, r_hw, ($urandom_range(0, 5) == 0));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception controller, located at the M stage of the five-stage pipeline.
- Owns the SR, Cause, EPC and PRId registers.
- Raises the exception/interrupt request that redirects next-PC selection to the handler at 0x0000_4180.
- Supplies the EPC value that the next-PC logic uses on eret. Also services mfc0/mtc0 accesses.

Parameters:
- PRID_VALUE, 32'h2022_0707, constant returned on reads of register 15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; registers clear on the clk edge when reset==0.
- A1  in  5  mfc0 read register number (rd field).
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data (M-stage rt value).
- WE  in  1  mtc0 write enable.
- PC  in  32  PC of the instruction currently in M.
- BDIn  in  1  instruction in M is in a branch delay slot.
- ExcCodeIn  in  5  synchronous exception code of the M instruction; 0 = none.
- HWInt  in  6  external hardware interrupt lines, level-sensitive.
- EXLClr  in  1  eret is in M; clear EXL.
- Req  out  1  exception/interrupt taken this cycle.
- EPCOut  out  32  current EPC value, consumed by next-PC logic on eret.
- DOut  out  32  mfc0 read data.

Behaviour:

Register fields:
- SR (12):
  - IM = bits[15:10], R/W.
  - EXL = bit[1], R/W.
  - IE = bit[0], R/W.
  - All other bits read 0.
- Cause (13):
  - BD = bit[31], read-only.
  - IP = bits[15:10], read-only; loaded from HWInt every cycle, not reset-gated beyond the reset cycle.
  - ExcCode = bits[6:2], read-only.
  - All other bits read 0.
- EPC (14): 32-bit, R/W.
- PRId (15): PRID_VALUE, read-only.

Reset:
- When reset==0 at an edge, SR, Cause and EPC all become 0.
- EPCOut=0 after reset.
- Req must be 0 after reset, since IE=0 and EXL=0 with ExcCodeIn inputs quiet.

Request generation (combinational, same cycle as inputs):
- IntReq = IE & ~EXL & |(HWInt & IM).
- ExcReq = ~EXL & (ExcCodeIn != 0).
- Req = IntReq | ExcReq.
- Interrupt has priority over a synchronous exception.

On a clk edge with Req==1:
- EXL <= 1.
- BD <= BDIn.
- ExcCode <= IntReq ? 5'd0 : ExcCodeIn.
- EPC <= BDIn ? (PC - 4) : PC, with bits[1:0] forced to 0.

Priorities within one edge, highest first: reset, Req, EXLClr, WE.
- While Req==1, the mtc0 write is discarded.
- While Req==1, EXLClr is ignored; EXL ends the edge at 1.
- EXLClr with no Req: EXL <= 0.
- If WE targets SR in the same cycle as EXLClr, the written SR value applies except that EXL is forced to 0.

mtc0 (WE==1, no Req):
- A2==12 writes the IM/EXL/IE fields.
- A2==14 writes the full EPC.
- Writes to 13, 15 or any unmapped number have no effect.

mfc0:
- DOut is combinational from A1 over the current register values.
- Unmapped numbers return 0.
- A read and a write to the same register in the same cycle return the old value.

EPCOut:
- Equals the EPC register.
- Updates the cycle after a taken Req or an mtc0 to EPC.

Nesting:
- While EXL==1 no new request is raised, including when ExcCodeIn!=0.
- Cause.IP continues to track HWInt while EXL==1.

Optional Feature:
- Macro: CP0_EPC_BYPASS_EN.
- Defined: when WE==1, A2==14 and Req==0, EPCOut = DIn combinationally in that cycle. An eret decoded in D directly behind an mtc0 EPC in M therefore targets the new value with no stall.
- Undefined: EPCOut is always the EPC register. The hazard unit must stall eret in D while mtc0-to-EPC is in E or M.

Test Plan:
- Reset/PRId:
  - Stimulus: hold reset=0 for 2 cycles, release; mfc0 A1=12/13/14/15.
  - Required: DOut = 0/0/0/PRID_VALUE; Req=0.
- Synchronous exception:
  - Stimulus: mtc0 SR=0x0000_FC01; then ExcCodeIn=12, PC=0x0000_3010, BDIn=0.
  - Required: Req=1 that cycle. Next cycle: EPC=0x0000_3010, Cause=0x0000_0030 (ExcCode=12), SR.EXL=1, Req=0 with ExcCodeIn still 12.
- Delay-slot interrupt:
  - Stimulus: SR=0x0000_0401, HWInt=6'b000001, PC=0x0000_3024, BDIn=1.
  - Required: Req=1. Next cycle: EPC=0x0000_3020, Cause[31]=1, Cause[10]=1, ExcCode=0.
- Masking:
  - Stimulus: HWInt=6'b000010 with IM=6'b000001, or with IE=0.
  - Required: Req=0; Cause.IP reads 6'b000010.
- eret vs write priority:
  - Stimulus: with EXL=1, assert EXLClr.
  - Required: EXL=0 next cycle.
  - Stimulus: Req and WE (A2=14, DIn=0xDEAD_BEEC) in the same cycle.
  - Required: EPC holds the exception PC, not DIn.
- Bypass:
  - Stimulus: with CP0_EPC_BYPASS_EN defined, WE=1, A2=14, DIn=0x0000_3100.
  - Required: EPCOut=0x0000_3100 in the same cycle.
  - Without the macro: EPCOut changes one cycle later.
